// File: rtl/alu_wb_buffer_pkg.sv
// Shared types and constants for the ALU writeback buffer.
// Optional feature macro: ALU_WB_BYPASS_EN (see alu_wb_buffer.sv).
package alu_wb_buffer_pkg;

  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 4;
  localparam int unsigned WB_MIN_DEPTH  = 2;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned TRANS_ID_BITS;
  } cfg_t;

  localparam cfg_t cva6_cfg_empty = '{
    XLEN:          XLEN,
    TRANS_ID_BITS: TRANS_ID_BITS
  };

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     src_mul;
  } wb_entry_t;

  function automatic bit wb_depth_ok(input int unsigned d);
    return (d >= WB_MIN_DEPTH) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/alu_wb_buffer_fifo.sv
// Dual-push / single-pop circular FIFO of writeback entries.
// Push port 0 is written before push port 1 when both fire.
module alu_wb_buffer_fifo
  import alu_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          push0_i,
  input  wb_entry_t     data0_i,
  input  logic          push1_i,
  input  wb_entry_t     data1_i,
  input  logic          pop_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr1;
  logic [CW-1:0] npush;

  always_comb begin
    wptr1  = wptr_q + PW'(push0_i);
    npush  = CW'(push0_i) + CW'(push1_i);
    wptr_d = wptr_q + PW'(npush);
    rptr_d = rptr_q + PW'(pop_i);
    cnt_d  = cnt_q + npush - CW'(pop_i);
    if (clr_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      if (!clr_i && push0_i) mem_q[wptr_q] <= data0_i;
      if (!clr_i && push1_i) mem_q[wptr1]  <= data1_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_wb_buffer.sv
// ALU / multi-cycle result writeback buffer in front of the scoreboard.
// Define ALU_WB_BYPASS_EN for a zero-latency path when the FIFO is empty.
module alu_wb_buffer
  import alu_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter cfg_t        CVA6Cfg = cva6_cfg_empty
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  output logic                     alu_ready_o,
  input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     mul_valid_i,
  input  logic [TRANS_ID_BITS-1:0] mul_trans_id_i,
  input  logic [XLEN-1:0]          mul_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_src_mul_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  wb_entry_t     alu_e, mul_e, head;
  logic [CW-1:0] cnt, free;
  logic          empty, alu_push;
  logic          f_push0, f_push1, f_pop;
  logic          byp_mul, byp_alu;

  assign alu_e = '{trans_id: alu_trans_id_i,
                   result:   alu_result_i,
                   src_mul:  1'b0};
  assign mul_e = '{trans_id: mul_trans_id_i,
                   result:   mul_result_i,
                   src_mul:  1'b1};

  // One slot stays free so a same-cycle mul result always fits.
  assign free        = DepthC - cnt;
  assign empty       = (cnt == '0);
  assign alu_ready_o = (free >= CW'(2));
  assign alu_push    = alu_valid_i & alu_ready_o;

`ifdef ALU_WB_BYPASS_EN
  logic byp_ok;
  assign byp_ok  = empty & wb_ready_i & ~flush_i;
  assign byp_mul = byp_ok & mul_valid_i;
  assign byp_alu = byp_ok & alu_push & ~mul_valid_i;
`else
  assign byp_mul = 1'b0;
  assign byp_alu = 1'b0;
`endif

  assign f_push0 = mul_valid_i & ~byp_mul & ~flush_i;
  assign f_push1 = alu_push & ~byp_alu & ~flush_i;
  assign f_pop   = ~empty & wb_ready_i;

  alu_wb_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (flush_i),
    .push0_i (f_push0),
    .data0_i (mul_e),
    .push1_i (f_push1),
    .data1_i (alu_e),
    .pop_i   (f_pop),
    .head_o  (head),
    .count_o (cnt)
  );

  always_comb begin
    wb_valid_o    = 1'b0;
    wb_trans_id_o = '0;
    wb_result_o   = '0;
    wb_src_mul_o  = 1'b0;
    unique case (1'b1)
      byp_mul: begin
        wb_valid_o    = 1'b1;
        wb_trans_id_o = mul_e.trans_id;
        wb_result_o   = mul_e.result;
        wb_src_mul_o  = 1'b1;
      end
      byp_alu: begin
        wb_valid_o    = 1'b1;
        wb_trans_id_o = alu_e.trans_id;
        wb_result_o   = alu_e.result;
        wb_src_mul_o  = 1'b0;
      end
      default: begin
        if (!empty) begin
          wb_valid_o    = 1'b1;
          wb_trans_id_o = head.trans_id;
          wb_result_o   = head.result;
          wb_src_mul_o  = head.src_mul;
        end
      end
    endcase
  end

  a_cfg : assert property (@(posedge clk_i)
    wb_depth_ok(DEPTH) &&
    CVA6Cfg.XLEN == XLEN &&
    CVA6Cfg.TRANS_ID_BITS == TRANS_ID_BITS);

  a_mul_ovf : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(f_push0 && cnt == DepthC));

  a_push_fit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (CW'(f_push0) + CW'(f_push1)) <= free);

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed self-checking bench for alu_wb_buffer (default build).
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_alu_wb_buffer;
  import alu_wb_buffer_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic alu_v = 1'b0, alu_rdy;
  logic [TRANS_ID_BITS-1:0] alu_id = '0;
  logic [XLEN-1:0] alu_res = '0;
  logic mul_v = 1'b0;
  logic [TRANS_ID_BITS-1:0] mul_id = '0;
  logic [XLEN-1:0] mul_res = '0;
  logic wb_v, wb_rdy = 1'b0, wb_src;
  logic [TRANS_ID_BITS-1:0] wb_id;
  logic [XLEN-1:0] wb_res;

  int n_cmp = 0;
  int n_err = 0;

  alu_wb_buffer #(.DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .alu_valid_i    (alu_v),
    .alu_ready_o    (alu_rdy),
    .alu_trans_id_i (alu_id),
    .alu_result_i   (alu_res),
    .mul_valid_i    (mul_v),
    .mul_trans_id_i (mul_id),
    .mul_result_i   (mul_res),
    .wb_valid_o     (wb_v),
    .wb_ready_i     (wb_rdy),
    .wb_trans_id_o  (wb_id),
    .wb_result_o    (wb_res),
    .wb_src_mul_o   (wb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input int id,
                      input int res, input logic src);
    chk({tag, "_v"}, 64'(wb_v), 64'd1);
    chk({tag, "_id"}, 64'(wb_id), 64'(id));
    chk({tag, "_res"}, 64'(wb_res), 64'(res));
    chk({tag, "_src"}, 64'(wb_src), 64'(src));
  endtask

  task automatic zero_out(input string tag);
    chk({tag, "_v"}, 64'(wb_v), 64'd0);
    chk({tag, "_id"}, 64'(wb_id), 64'd0);
    chk({tag, "_res"}, 64'(wb_res), 64'd0);
    chk({tag, "_src"}, 64'(wb_src), 64'd0);
    chk({tag, "_rdy"}, 64'(alu_rdy), 64'd1);
  endtask

  initial begin
    int sent, got_n;
    #1;
    zero_out("rst");
    #11 rst_n = 1'b1;

    // single ALU push, popped the cycle it appears
    alu_v = 1; alu_id = 3; alu_res = 32'h1234; wb_rdy = 1;
    tick();
    alu_v = 0;
    head("single", 3, 32'h1234, 1'b0);
    tick();
    chk("single_empty", 64'(wb_v), 64'd0);

    // dual push: mul ahead of ALU
    alu_v = 1; alu_id = 5; alu_res = 32'hAA;
    mul_v = 1; mul_id = 6; mul_res = 32'hBB;
    tick();
    alu_v = 0; mul_v = 0;
    head("dual0", 6, 32'hBB, 1'b1);
    tick();
    head("dual1", 5, 32'hAA, 1'b0);
    tick();
    chk("dual_empty", 64'(wb_v), 64'd0);

    // back-pressure with wb_ready low
    wb_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      alu_v = 1; alu_id = 4'(i); alu_res = 32'h100 + 32'(i);
      tick();
      chk("bp_rdy", 64'(alu_rdy), (i < 2) ? 64'd1 : 64'd0);
      head("bp_hold", 0, 32'h100, 1'b0);
    end
    alu_v = 0;
    mul_v = 1; mul_id = 7; mul_res = 32'h777;
    tick();
    mul_v = 0;
    chk("bp_full_rdy", 64'(alu_rdy), 64'd0);
    wb_rdy = 1;
    head("bp_d0", 0, 32'h100, 1'b0);
    tick();
    head("bp_d1", 1, 32'h101, 1'b0);
    tick();
    head("bp_d2", 2, 32'h102, 1'b0);
    tick();
    head("bp_d3", 7, 32'h777, 1'b1);
    tick();
    chk("bp_empty", 64'(wb_v), 64'd0);
    chk("bp_rdy_back", 64'(alu_rdy), 64'd1);

    // wrap-around with alternating ready
    sent = 0; got_n = 0;
    for (int c = 0; c < 80 && got_n < 10; c++) begin
      wb_rdy = c[0];
      alu_v = (sent < 10);
      alu_id = 4'(sent);
      alu_res = 32'h2000 + 32'(sent);
      if (wb_v && wb_rdy) begin
        chk("wrap_id", 64'(wb_id), 64'(got_n));
        chk("wrap_res", 64'(wb_res), 64'h2000 + 64'(got_n));
        got_n++;
      end
      if (alu_v && alu_rdy) sent++;
      tick();
    end
    alu_v = 0;
    chk("wrap_count", 64'(got_n), 64'd10);
    chk("wrap_empty", 64'(wb_v), 64'd0);

    // flush with a same-cycle push and pop
    wb_rdy = 0;
    for (int i = 1; i <= 3; i++) begin
      alu_v = 1; alu_id = 4'(i); alu_res = 32'(i);
      tick();
    end
    alu_v = 0;
    head("fl_pre", 1, 1, 1'b0);
    flush = 1; wb_rdy = 1;
    mul_v = 1; mul_id = 4; mul_res = 32'h44;
    tick();
    flush = 0; mul_v = 0; wb_rdy = 0;
    chk("fl_v", 64'(wb_v), 64'd0);
    chk("fl_rdy", 64'(alu_rdy), 64'd1);
    alu_v = 1; alu_id = 7; alu_res = 32'h77;
    tick();
    alu_v = 0;
    head("fl_post", 7, 32'h77, 1'b0);
    tick();
    head("fl_stall", 7, 32'h77, 1'b0);
    wb_rdy = 1;
    tick();
    chk("fl_alone", 64'(wb_v), 64'd0);

    // async reset mid-drain
    wb_rdy = 0;
    alu_v = 1; alu_id = 8; alu_res = 32'h88;
    tick();
    alu_id = 9; alu_res = 32'h99;
    tick();
    alu_v = 0; wb_rdy = 1;
    tick();
    head("ar_pre", 9, 32'h99, 1'b0);
    #2 rst_n = 1'b0;
    #1 zero_out("ar");
    #2 rst_n = 1'b1;
    alu_v = 1; alu_id = 2; alu_res = 32'h55;
    tick();
    alu_v = 0;
    head("ar_post", 2, 32'h55, 1'b0);
    tick();
    chk("ar_empty", 64'(wb_v), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
